// File: rtl/mem_ctrl_pkg.sv
// Shared types and decode helpers for the MEM-stage controller.
// Defines the FSM state encoding and the load/store request decode.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic ren;
        logic wen;
    } dreq_t;

    // Both dREN and dWEN set is illegal; the load wins so a store is never issued by accident.
    function automatic dreq_t decode_req(input logic valid, input logic ren, input logic wen);
        dreq_t r;
        r.ren = valid & ren;
        r.wen = valid & wen & ~ren;
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage dcache request controller feeding the MEM/WB register.
// Issues loads/stores, holds hit data across pipeline stalls, and freezes on HALT.
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_EX_MEM,
    input  logic              dREN_EX_MEM,
    input  logic              dWEN_EX_MEM,
    input  logic              halt_EX_MEM,
    input  logic [WORD_W-1:0] result_EX_MEM,
    input  logic [WORD_W-1:0] dmemstore_EX_MEM,
    input  logic              pipe_stall,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload_cache,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload,
    output logic              enable_MEM_WB,
    output logic              flush_MEM_WB,
    output logic              mem_stall,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles
);

    mem_state_t        state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;

    dreq_t             req;
    logic              memop;
    logic              ren_w, wen_w, en_w, flush_w, stall_w, halted_w;
    logic [WORD_W-1:0] addr_w, store_w, load_w;

    assign req   = decode_req(valid_EX_MEM, dREN_EX_MEM, dWEN_EX_MEM);
    assign memop = req.ren | req.wen;

    // Outputs are forced low during reset so an in-flight request drops immediately.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ren_w    = 1'b0;
        wen_w    = 1'b0;
        en_w     = 1'b0;
        flush_w  = 1'b0;
        stall_w  = 1'b0;
        halted_w = 1'b0;
        addr_w   = '0;
        store_w  = '0;
        load_w   = '0;
        if (!RST) begin
            case (state_q)
                IDLE, WAIT: begin
                    ren_w   = req.ren;
                    wen_w   = req.wen;
                    addr_w  = result_EX_MEM;
                    store_w = dmemstore_EX_MEM;
                    load_w  = dmemload_cache;
                    if (memop) begin
                        if (!dhit) begin
                            stall_w = 1'b1;
                            flush_w = 1'b1;
                            state_d = WAIT;
                        end else if (!pipe_stall) begin
                            en_w    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            hold_d  = dmemload_cache;
                            state_d = DONE;
                        end
                    end else begin
                        en_w    = ~pipe_stall;
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    // Request already completed; never reissue it while waiting on the pipe.
                    addr_w = result_EX_MEM;
                    load_w = hold_q;
                    en_w   = ~pipe_stall;
                    if (!pipe_stall) begin
                        state_d = IDLE;
                    end
                end
                HALTED: begin
                    halted_w = 1'b1;
                    stall_w  = 1'b1;
                    load_w   = hold_q;
                end
                default: state_d = IDLE;
            endcase
            if (valid_EX_MEM && halt_EX_MEM && en_w) begin
                state_d = HALTED;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i  (CLK),
        .rst_i  (RST),
        .en_i   (stall_w && (state_q != HALTED)),
        .count_o(stall_cycles)
    );

    assign dmemREN       = ren_w;
    assign dmemWEN       = wen_w;
    assign dmemaddr      = addr_w;
    assign dmemstore     = store_w;
    assign dmemload      = load_w;
    assign enable_MEM_WB = en_w;
    assign flush_MEM_WB  = flush_w;
    assign mem_stall     = stall_w;
    assign halted        = halted_w;

endmodule
